// File: rtl/mips_pkg.sv
// Opcode/funct encodings and the W-stage write record, shared by the D-stage
// decoder, the hazard unit and the writeback stage.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_wr_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

endpackage

// File: rtl/w_writeback_grf_if.sv
// MEM/WB pipeline-register outputs as seen by the writeback stage.
interface w_writeback_grf_if;
    logic [31:0] IR_W;
    logic [31:0] pc_W;
    logic [31:0] pc4_W;
    logic [31:0] ALUout_W;
    logic [31:0] DMout_W;

    modport master (output IR_W, pc_W, pc4_W, ALUout_W, DMout_W);
    modport slave  (input  IR_W, pc_W, pc4_W, ALUout_W, DMout_W);
endinterface

// File: rtl/w_load_ext.sv
// Little-endian byte/halfword selection and sign/zero extension of a loaded word.
module w_load_ext
    import mips_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] dm,
    output logic [31:0] ld
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte and halfword lane select; addr[0] is ignored for halfwords.
    always_comb begin
        case (addr)
            2'd0:    byte_s = dm[7:0];
            2'd1:    byte_s = dm[15:8];
            2'd2:    byte_s = dm[23:16];
            2'd3:    byte_s = dm[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr[1]) begin
            half_s = dm[31:16];
        end else begin
            half_s = dm[15:0];
        end
    end

    // Extension according to the load flavour.
    always_comb begin
        case (op)
            OP_LB:   ld = {{24{byte_s[7]}}, byte_s};
            OP_LBU:  ld = {24'h000000, byte_s};
            OP_LH:   ld = {{16{half_s[15]}}, half_s};
            OP_LHU:  ld = {16'h0000, half_s};
            OP_LW:   ld = dm;
            default: ld = dm;
        endcase
    end

endmodule

// File: rtl/w_writeback_grf.sv
// Writeback stage: decodes IR_W into a GPR write, owns the 32x32 register file
// with write-through read ports, and counts retired instructions.
module w_writeback_grf
    import mips_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int CNT_W  = 32,
    parameter int BYPASS = 1
)(
    input  logic               clk,
    input  logic               reset,
    w_writeback_grf_if.slave   mw,
    input  logic [4:0]         ra1,
    input  logic [4:0]         ra2,
    output logic [31:0]        rd1,
    output logic [31:0]        rd2,
    output logic               w_we,
    output logic [4:0]         w_addr,
    output logic [31:0]        w_data,
    output logic [CNT_W-1:0]   retire_cnt
);

    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [31:0] ld_s;
    logic        bubble_s;
    wb_wr_t      dec_s;
    wb_wr_t      wr_s;
    logic        unused_bits;

    logic [31:0]      grf_r [0:NREG-1];
    logic [CNT_W-1:0] cnt_r;

    assign op_s     = mw.IR_W[31:26];
    assign rt_s     = mw.IR_W[20:16];
    assign rd_s     = mw.IR_W[15:11];
    assign funct_s  = mw.IR_W[5:0];
    assign bubble_s = (mw.IR_W == 32'h0000_0000);

    // rs and shamt are consumed earlier in the pipe; pc_W is trace-only.
    assign unused_bits = ^{mw.pc_W, mw.IR_W[25:21], mw.IR_W[10:6]};

    w_load_ext u_load_ext (
        .op   (op_s),
        .addr (mw.ALUout_W[1:0]),
        .dm   (mw.DMout_W),
        .ld   (ld_s)
    );

    // Raw decode: which register would be written, and with what.
    always_comb begin
        dec_s = '{we: 1'b0, addr: 5'd0, data: 32'h0000_0000};
        case (op_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_JR, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO: begin
                        dec_s.we = 1'b0;
                    end
                    FN_JALR: begin
                        dec_s = '{we: 1'b1, addr: rd_s, data: mw.pc4_W + 32'd4};
                    end
                    default: begin
                        dec_s = '{we: 1'b1, addr: rd_s, data: mw.ALUout_W};
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec_s = '{we: 1'b1, addr: rt_s, data: mw.ALUout_W};
            end
            OP_JAL: begin
                dec_s = '{we: 1'b1, addr: REG_RA, data: mw.pc4_W + 32'd4};
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dec_s = '{we: 1'b1, addr: rt_s, data: ld_s};
            end
            default: begin
                dec_s.we = 1'b0;
            end
        endcase
    end

    // $0 and bubbles never write; addr/data are zeroed so the hazard unit sees a clean idle.
    always_comb begin
        if (dec_s.we && (dec_s.addr != 5'd0) && !bubble_s) begin
            wr_s = dec_s;
        end else begin
            wr_s = '{we: 1'b0, addr: 5'd0, data: 32'h0000_0000};
        end
    end

    assign w_we   = wr_s.we;
    assign w_addr = wr_s.addr;
    assign w_data = wr_s.data;

    // Register-file write; reset clears every entry and wins over a pending write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                grf_r[i] <= 32'h0000_0000;
            end
        end else if (wr_s.we) begin
            grf_r[wr_s.addr] <= wr_s.data;
        end else begin
            grf_r[0] <= 32'h0000_0000;
        end
    end

    // Retired-instruction counter, wraps naturally at all ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!bubble_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign retire_cnt = cnt_r;

    // Read ports with optional write-through of the value being written this cycle.
    always_comb begin
        if (ra1 == 5'd0) begin
            rd1 = 32'h0000_0000;
        end else if ((BYPASS != 0) && wr_s.we && (ra1 == wr_s.addr)) begin
            rd1 = wr_s.data;
        end else begin
            rd1 = grf_r[ra1];
        end
        if (ra2 == 5'd0) begin
            rd2 = 32'h0000_0000;
        end else if ((BYPASS != 0) && wr_s.we && (ra2 == wr_s.addr)) begin
            rd2 = wr_s.data;
        end else begin
            rd2 = grf_r[ra2];
        end
    end

endmodule

// File: tb/tb_w_writeback_grf.sv
// Directed bench for w_writeback_grf: a bypassing 32-bit-counter instance and a
// non-bypassing 3-bit-counter instance run side by side against one reference model.
module tb_w_writeback_grf;
    import mips_pkg::*;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1_a, rd2_a, w_data_a, rd1_b, rd2_b, w_data_b;
    logic        w_we_a, w_we_b;
    logic [4:0]  w_addr_a, w_addr_b;
    logic [31:0] cnt_a;
    logic [2:0]  cnt_b;

    w_writeback_grf_if mw();

    w_writeback_grf #(.NREG(32), .CNT_W(32), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .mw(mw), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_a), .rd2(rd2_a), .w_we(w_we_a), .w_addr(w_addr_a),
        .w_data(w_data_a), .retire_cnt(cnt_a));

    w_writeback_grf #(.NREG(32), .CNT_W(3), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .mw(mw), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_b), .rd2(rd2_b), .w_we(w_we_b), .w_addr(w_addr_b),
        .w_data(w_data_b), .retire_cnt(cnt_b));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_grf [32];
    logic [31:0] m_cnt;
    logic        m_valid = 1'b0;
    wb_wr_t      m_e;

    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] ea,
                                           input logic [31:0] dm);
        logic [31:0]        sb, sh;
        logic signed [31:0] t;
        sb = dm >> (8 * ea[1:0]);
        sh = dm >> (ea[1] ? 16 : 0);
        case (op)
            OP_LB:   begin t = {sb[7:0], 24'h0};  return t >>> 24; end
            OP_LH:   begin t = {sh[15:0], 16'h0}; return t >>> 16; end
            OP_LBU:  return sb & 32'h0000_00FF;
            OP_LHU:  return sh & 32'h0000_FFFF;
            default: return dm;
        endcase
    endfunction

    function automatic wb_wr_t m_decode(input logic [31:0] ir, input logic [31:0] pc4,
                                        input logic [31:0] alu, input logic [31:0] dm);
        wb_wr_t e;
        logic [5:0] op, fn;
        op = ir[31:26];
        fn = ir[5:0];
        e  = '{we: 1'b0, addr: 5'd0, data: 32'd0};
        if (ir == 32'd0) return e;
        if (op == 6'd0) begin
            if (fn inside {FN_JR, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO}) return e;
            e.addr = ir[15:11];
            e.data = (fn == FN_JALR) ? pc4 + 32'd4 : alu;
        end else if (op >= 6'h08 && op <= 6'h0F) begin
            e.addr = ir[20:16];
            e.data = alu;
        end else if (op == 6'h03) begin
            e.addr = 5'd31;
            e.data = pc4 + 32'd4;
        end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
            e.addr = ir[20:16];
            e.data = m_load(op, alu, dm);
        end else begin
            return e;
        end
        if (e.addr == 5'd0) return '{we: 1'b0, addr: 5'd0, data: 32'd0};
        e.we = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] ra, input bit bypass);
        if (ra == 5'd0) return 32'd0;
        if (bypass && m_e.we && ra == m_e.addr) return m_e.data;
        return m_grf[ra];
    endfunction

    always_comb m_e = m_decode(mw.IR_W, mw.pc4_W, mw.ALUout_W, mw.DMout_W);

    // Model state advances on the same edge as the DUT.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_grf[i] <= 32'd0;
            m_cnt   <= 32'd0;
            m_valid <= 1'b1;
        end else begin
            if (m_e.we) m_grf[m_e.addr] <= m_e.data;
            if (mw.IR_W != 32'd0) m_cnt <= m_cnt + 32'd1;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("w_we_a",   {31'd0, w_we_a}, {31'd0, m_e.we});
            check("w_addr_a", {27'd0, w_addr_a}, {27'd0, m_e.addr});
            check("w_data_a", w_data_a, m_e.data);
            check("w_we_b",   {31'd0, w_we_b}, {31'd0, m_e.we});
            check("w_addr_b", {27'd0, w_addr_b}, {27'd0, m_e.addr});
            check("w_data_b", w_data_b, m_e.data);
            check("rd1_a", rd1_a, m_read(ra1, 1'b1));
            check("rd2_a", rd2_a, m_read(ra2, 1'b1));
            check("rd1_b", rd1_b, m_read(ra1, 1'b0));
            check("rd2_b", rd2_b, m_read(ra2, 1'b0));
            check("cnt_a", cnt_a, m_cnt);
            check("cnt_b", {29'd0, cnt_b}, {29'd0, m_cnt[2:0]});
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic drive(input logic [31:0] ir, input logic [31:0] alu,
                         input logic [31:0] dm, input logic [31:0] pc4);
        mw.IR_W     = ir;
        mw.ALUout_W = alu;
        mw.DMout_W  = dm;
        mw.pc4_W    = pc4;
        mw.pc_W     = pc4 - 32'd4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] ea;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t ld_tab [8];

    initial begin
        ld_tab[0] = '{OP_LB,  32'h0000_1002, 32'hFFFF_FFFF};
        ld_tab[1] = '{OP_LB,  32'h0000_1001, 32'h0000_007F};
        ld_tab[2] = '{OP_LBU, 32'h0000_1003, 32'h0000_0080};
        ld_tab[3] = '{OP_LH,  32'h0000_1002, 32'hFFFF_80FF};
        ld_tab[4] = '{OP_LHU, 32'h0000_1002, 32'h0000_80FF};
        ld_tab[5] = '{OP_LW,  32'h0000_1001, 32'h80FF_7F01};
        ld_tab[6] = '{OP_LH,  32'h0000_1001, 32'h0000_7F01};
        ld_tab[7] = '{OP_LB,  32'h0000_1003, 32'hFFFF_FF80};

        // 1. reset with a writing instruction present
        reset = 1'b0; ra1 = 5'd8; ra2 = 5'd0;
        drive(enc_i(OP_ADDIU, 5'd0, 5'd8, 16'd5), 32'd5, 32'd0, 32'd4);
        tick(); tick();
        reset = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 32'd8);
        @(negedge clk);
        check("t1_rd1_after_reset", rd1_a, 32'd0);
        check("t1_cnt_after_reset", cnt_a, 32'd0);
        tick();

        // 2. R-type write with same-cycle bypass
        ra1 = 5'd9;
        drive(enc_r(5'd8, 5'd8, 5'd9, FN_ADDU), 32'h0000_000A, 32'd0, 32'h0000_2004);
        @(negedge clk);
        check("t2_we", {31'd0, w_we_a}, 32'd1);
        check("t2_addr", {27'd0, w_addr_a}, 32'd9);
        check("t2_bypass_rd1", rd1_a, 32'h0000_000A);
        check("t2_nobypass_rd1", rd1_b, 32'd0);
        tick();
        drive(32'd0, 32'd0, 32'd0, 32'h0000_2008);
        @(negedge clk);
        check("t2_rd1_next_a", rd1_a, 32'h0000_000A);
        check("t2_rd1_next_b", rd1_b, 32'h0000_000A);
        tick();

        // 3. load extension table
        ra1 = 5'd3;
        foreach (ld_tab[i]) begin
            drive(enc_i(ld_tab[i].op, 5'd4, 5'd3, 16'd0), ld_tab[i].ea, 32'h80FF_7F01, 32'h0000_2100);
            @(negedge clk);
            check($sformatf("t3_load_%0d", i), w_data_a, ld_tab[i].exp);
            tick();
        end

        // 4. jal / jalr and assorted non-writers
        drive({OP_JAL, 26'h0000_400}, 32'd0, 32'd0, 32'h0000_3004);
        tick();
        ra2 = 5'd31;
        drive(enc_r(5'd5, 5'd0, 5'd0, FN_JALR), 32'h0000_1234, 32'd0, 32'h0000_3100);
        ra1 = 5'd0;
        @(negedge clk);
        check("t4_jal_rd2", rd2_a, 32'h0000_3008);
        check("t4_jalr_rd0_we", {31'd0, w_we_a}, 32'd0);
        check("t4_rd1_zero", rd1_a, 32'd0);
        tick();
        ra1 = 5'd14;
        drive(enc_r(5'd5, 5'd0, 5'd14, FN_JALR), 32'h0000_1234, 32'd0, 32'h0000_0100);
        @(negedge clk);
        check("t4_jalr_data", w_data_a, 32'h0000_0104);
        tick();
        drive(enc_r(5'd31, 5'd0, 5'd0, FN_JR), 32'h1, 32'd0, 32'h0);          tick();
        drive(enc_r(5'd1, 5'd2, 5'd7, FN_MULT), 32'h55, 32'd0, 32'h0);         tick();
        drive(enc_r(5'd1, 5'd2, 5'd7, FN_MTLO), 32'h56, 32'd0, 32'h0);         tick();
        drive(enc_i(OP_SW, 5'd1, 5'd9, 16'h4), 32'h0000_0010, 32'd0, 32'h0);   tick();
        drive(enc_i(OP_BEQ, 5'd1, 5'd9, 16'h4), 32'h0000_0020, 32'd0, 32'h0);  tick();
        drive(enc_i(OP_ORI, 5'd0, 5'd12, 16'hBEEF), 32'h0000_BEEF, 32'd0, 32'h0); tick();
        drive(enc_i(OP_LUI, 5'd0, 5'd13, 16'hCAFE), 32'hCAFE_0000, 32'd0, 32'h0); tick();
        ra1 = 5'd12; ra2 = 5'd13;
        drive(enc_i(OP_ADDI, 5'd0, 5'd0, 16'h7), 32'h7, 32'd0, 32'h0);
        @(negedge clk);
        check("t4_addi_rt0_we", {31'd0, w_we_a}, 32'd0);
        check("t4_ori_rd", rd1_a, 32'h0000_BEEF);
        check("t4_lui_rd", rd2_a, 32'hCAFE_0000);
        tick();

        // 5. retire counter, including wrap of the 3-bit instance
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(enc_i(OP_ORI, 5'd0, 5'd20 + 5'(i), 16'(i)), 32'(i + 1), 32'd0, 32'd0);
            tick();
        end
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        check("t5_cnt3_a", cnt_a, 32'd3);
        check("t5_cnt3_b", {29'd0, cnt_b}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            drive(enc_r(5'd1, 5'd2, 5'd0, FN_MULTU), 32'd0, 32'd0, 32'd0);
            tick();
        end
        check("t5_cnt7_b", {29'd0, cnt_b}, 32'd7);
        drive(enc_r(5'd1, 5'd2, 5'd0, FN_DIV), 32'd0, 32'd0, 32'd0);
        tick();
        check("t5_wrap_b", {29'd0, cnt_b}, 32'd0);
        check("t5_cnt8_a", cnt_a, 32'd8);

        // 6. write discarded under reset, then resumes
        ra1 = 5'd10; ra2 = 5'd10;
        drive(enc_i(OP_ORI, 5'd0, 5'd10, 16'h55), 32'h0000_0055, 32'd0, 32'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("t6_discarded_a", rd1_a, 32'd0);
        check("t6_discarded_b", rd1_b, 32'd0);
        check("t6_cnt_reset", cnt_a, 32'd0);
        tick();
        drive(enc_i(OP_ORI, 5'd0, 5'd10, 16'h55), 32'h0000_0055, 32'd0, 32'd0);
        @(negedge clk);
        check("t6_bypass_a", rd2_a, 32'h0000_0055);
        check("t6_old_b", rd2_b, 32'd0);
        tick();
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("t6_resumed_b", rd1_b, 32'h0000_0055);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
